// File: rtl/fifo_ctrl_if.sv
// FIFO controller handshake/status bundle between producer/consumer and the controller.
// Latency: n/a (signal grouping only).
// Backpressure: producer watches full/wr_en, consumer watches empty.
interface fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 2
);
  logic                  wr;
  logic                  rd;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  // Producer/consumer side: issues push/pop requests, observes status.
  modport master (
    output wr, rd,
    input  wr_en, w_addr, r_addr, empty, full, count, overflow, underflow
  );

  // Controller side.
  modport slave (
    input  wr, rd,
    output wr_en, w_addr, r_addr, empty, full, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller turning a 2^ADDR_WIDTH register file into a synchronous FIFO.
// Latency: pointers/flags/count update on the edge that accepts a push/pop; head data is read combinationally.
// Backpressure: pushes rejected while full (unless a pop frees the slot that cycle), pops rejected while empty; rejects pulse overflow/underflow.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  fifo_ctrl_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] COUNT_MAX = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  push, pop;

  // Next-state: accept decisions, pointer/count advance, flags from next count.
  always_comb begin
    // A push while full is still accepted when a pop frees the head slot in
    // the same cycle; the write then lands in the slot being vacated, so the
    // register-file write must be enabled for that case too.
    push    = bus.wr & (~full_q | bus.rd);
    pop     = bus.rd & ~empty_q;
    w_ptr_d = w_ptr_q + ADDR_WIDTH'(push);
    r_ptr_d = r_ptr_q + ADDR_WIDTH'(pop);
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == COUNT_MAX);
    ovf_d   = bus.wr & ~push;
    udf_d   = bus.rd & ~pop;
  end

  // State registers; asynchronous reset returns the FIFO to empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign bus.wr_en     = push;
  assign bus.w_addr    = w_ptr_q;
  assign bus.r_addr    = r_ptr_q;
  assign bus.count     = count_q;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;

endmodule
